// File: rtl/t01_ai_pkg.sv
// Shared types and constants for the Tetris AI move scorer.
package t01_ai_pkg;

    localparam int SCORE_W = 20;

    // Most negative representable score; any real candidate beats it.
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    localparam logic [7:0] W_LINES_DEF  = 8'd76;
    localparam logic [7:0] W_HOLES_DEF  = 8'd36;
    localparam logic [7:0] W_BUMP_DEF   = 8'd18;
    localparam logic [7:0] W_HEIGHT_DEF = 8'd51;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_EXTRACT = 3'd2,
        ST_SCORE   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } scorer_state_t;

endpackage

// File: rtl/t01_ai_score_calc.sv
// Registered weighted-sum scorer: one cycle from features to signed score.
// Products are at most 255*255, so every term fits in 16 unsigned bits and the
// sum of three penalties cannot reach the 20-bit signed minimum.
module t01_ai_score_calc
    import t01_ai_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [2:0]                lines_cleared,
    input  logic [7:0]                holes,
    input  logic [7:0]                bumpiness,
    input  logic [7:0]                height_sum,
    input  logic [7:0]                w_lines,
    input  logic [7:0]                w_holes,
    input  logic [7:0]                w_bump,
    input  logic [7:0]                w_height,
    output logic signed [SCORE_W-1:0] score
);

    logic [15:0]               p_lines_s;
    logic [15:0]               p_holes_s;
    logic [15:0]               p_bump_s;
    logic [15:0]               p_height_s;
    logic signed [SCORE_W-1:0] sum_s;

    // Zero-extended products combined into a signed sum
    always_comb begin
        p_lines_s  = {8'd0, w_lines}  * {13'd0, lines_cleared};
        p_holes_s  = {8'd0, w_holes}  * {8'd0, holes};
        p_bump_s   = {8'd0, w_bump}   * {8'd0, bumpiness};
        p_height_s = {8'd0, w_height} * {8'd0, height_sum};
        sum_s      = $signed({4'd0, p_lines_s})
                   - $signed({4'd0, p_holes_s})
                   - $signed({4'd0, p_bump_s})
                   - $signed({4'd0, p_height_s});
    end

    // Score register, loaded only while the controller is in its scoring cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= {SCORE_W{1'b0}};
        end else if (en) begin
            score <= sum_s;
        end else begin
            score <= score;
        end
    end

endmodule

// File: rtl/t01_ai_move_scorer.sv
// Tetris AI search controller: walks every (rotation, column) candidate,
// requests its board, extracts features, scores it and keeps the best.
// Optional build macro T01_AI_ABORT_EN adds an abort_search input.
module t01_ai_move_scorer
    import t01_ai_pkg::*;
#(
    parameter int         NUM_ROT  = 4,
    parameter int         NUM_COL  = 10,
    parameter logic [7:0] W_LINES  = W_LINES_DEF,
    parameter logic [7:0] W_HOLES  = W_HOLES_DEF,
    parameter logic [7:0] W_BUMP   = W_BUMP_DEF,
    parameter logic [7:0] W_HEIGHT = W_HEIGHT_DEF
)(
    input  logic        clk,
    input  logic        reset,
`ifdef T01_AI_ABORT_EN
    input  logic        abort_search,
`endif
    input  logic        start_search,
    output logic        cand_req,
    output logic [1:0]  cand_rot,
    output logic [3:0]  cand_col,
    input  logic        cand_ack,
    input  logic        cand_legal,
    output logic        start_extract,
    input  logic        extract_ready,
    input  logic [2:0]  lines_cleared,
    input  logic [7:0]  holes,
    input  logic [7:0]  bumpiness,
    input  logic [7:0]  height_sum,
    output logic        busy,
    output logic        search_done,
    output logic        best_valid,
    output logic [1:0]  best_rot,
    output logic [3:0]  best_col,
    output logic [19:0] best_score
);

    localparam logic [1:0] ROT_LAST = 2'(NUM_ROT - 1);
    localparam logic [3:0] COL_LAST = 4'(NUM_COL - 1);

    scorer_state_t             state_r;
    scorer_state_t             base_nxt_s;
    scorer_state_t             state_nxt_s;
    logic                      abort_s;
    logic                      last_s;
    logic                      first_r;
    logic [2:0]                lines_r;
    logic [7:0]                holes_r;
    logic [7:0]                bump_r;
    logic [7:0]                height_r;
    logic signed [SCORE_W-1:0] score_s;
    logic signed [SCORE_W-1:0] best_r;

`ifdef T01_AI_ABORT_EN
    assign abort_s = abort_search;
`else
    assign abort_s = 1'b0;
`endif

    assign last_s = (cand_rot == ROT_LAST) && (cand_col == COL_LAST);

    // Next-state decode, with abort pre-empting every busy state except DONE
    always_comb begin
        base_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_search) base_nxt_s = ST_REQ;
                else              base_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (cand_ack) begin
                    if (cand_legal) base_nxt_s = ST_EXTRACT;
                    else            base_nxt_s = ST_NEXT;
                end else begin
                    base_nxt_s = ST_REQ;
                end
            end
            ST_EXTRACT: begin
                // The first cycle's ready may be left over from the previous candidate
                if (!first_r && extract_ready) base_nxt_s = ST_SCORE;
                else                           base_nxt_s = ST_EXTRACT;
            end
            ST_SCORE:   base_nxt_s = ST_COMPARE;
            ST_COMPARE: base_nxt_s = ST_NEXT;
            ST_NEXT: begin
                if (last_s) base_nxt_s = ST_DONE;
                else        base_nxt_s = ST_REQ;
            end
            ST_DONE:    base_nxt_s = ST_IDLE;
            default:    base_nxt_s = ST_IDLE;
        endcase

        if (abort_s && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            state_nxt_s = ST_DONE;
        end else begin
            state_nxt_s = base_nxt_s;
        end
    end

    // State register; handshake and status outputs are registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cand_req      <= 1'b0;
            start_extract <= 1'b0;
            busy          <= 1'b0;
            search_done   <= 1'b0;
            first_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cand_req      <= (state_nxt_s == ST_REQ);
            start_extract <= (state_nxt_s == ST_EXTRACT);
            busy          <= (state_nxt_s != ST_IDLE);
            search_done   <= (state_nxt_s == ST_DONE);
            first_r       <= (state_r != ST_EXTRACT);
        end
    end

    // Candidate counters: column is the inner loop, rotation the outer loop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_rot <= 2'd0;
            cand_col <= 4'd0;
        end else if ((state_r == ST_IDLE) && start_search) begin
            cand_rot <= 2'd0;
            cand_col <= 4'd0;
        end else if (state_r == ST_NEXT) begin
            if (cand_col == COL_LAST) begin
                cand_col <= 4'd0;
                cand_rot <= last_s ? 2'd0 : cand_rot + 2'd1;
            end else begin
                cand_col <= cand_col + 4'd1;
            end
        end else begin
            cand_rot <= cand_rot;
            cand_col <= cand_col;
        end
    end

    // Feature capture on the accepted extract_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_r  <= 3'd0;
            holes_r  <= 8'd0;
            bump_r   <= 8'd0;
            height_r <= 8'd0;
        end else if ((state_r == ST_EXTRACT) && !first_r && extract_ready) begin
            lines_r  <= lines_cleared;
            holes_r  <= holes;
            bump_r   <= bumpiness;
            height_r <= height_sum;
        end else begin
            lines_r  <= lines_r;
            holes_r  <= holes_r;
            bump_r   <= bump_r;
            height_r <= height_r;
        end
    end

    t01_ai_score_calc u_score_calc (
        .clk           (clk),
        .reset         (reset),
        .en            (state_r == ST_SCORE),
        .lines_cleared (lines_r),
        .holes         (holes_r),
        .bumpiness     (bump_r),
        .height_sum    (height_r),
        .w_lines       (W_LINES),
        .w_holes       (W_HOLES),
        .w_bump        (W_BUMP),
        .w_height      (W_HEIGHT),
        .score         (score_s)
    );

    // Best tracking; strict greater-than keeps the earliest of tied candidates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_r     <= SCORE_MIN;
            best_score <= 20'd0;
            best_rot   <= 2'd0;
            best_col   <= 4'd0;
            best_valid <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_search) begin
            best_r     <= SCORE_MIN;
            best_score <= SCORE_MIN;
            best_rot   <= 2'd0;
            best_col   <= 4'd0;
            best_valid <= 1'b0;
        end else if ((state_r == ST_COMPARE) && (score_s > best_r)) begin
            best_r     <= score_s;
            best_score <= score_s;
            best_rot   <= cand_rot;
            best_col   <= cand_col;
            best_valid <= 1'b1;
        end else begin
            best_r     <= best_r;
            best_score <= best_score;
            best_rot   <= best_rot;
            best_col   <= best_col;
            best_valid <= best_valid;
        end
    end

endmodule

// File: doc/t01_ai_move_scorer.md
Name: t01_ai_move_scorer

Overview:
- Search controller and scorer for the Tetris AI.
- Enumerates every (rotation, column) placement candidate and requests each resulting board from the upstream placement stage via a req/ack handshake.
- Drives the feature extractor's start_extract/extract_ready handshake and consumes the extracted features (lines_cleared, holes, bumpiness, height_sum).
- Computes a signed weighted score per candidate and reports the best placement to the game controller.

Parameters:
- NUM_ROT, 4, rotations enumerated (0..NUM_ROT-1), outer loop.
- NUM_COL, 10, columns enumerated (0..NUM_COL-1), inner loop.
- W_LINES, 8'd76, reward weight per cleared line.
- W_HOLES, 8'd36, penalty weight per hole.
- W_BUMP, 8'd18, penalty weight per unit of bumpiness.
- W_HEIGHT, 8'd51, penalty weight per unit of height_sum.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_search  in  1  pulse; begins a search from IDLE
- cand_req  out  1  candidate request to the placement stage
- cand_rot  out  2  rotation of the current candidate
- cand_col  out  4  column of the current candidate
- cand_ack  in  1  placement stage has the board ready
- cand_legal  in  1  placement is legal; valid only with cand_ack
- start_extract  out  1  level request to the feature extractor
- extract_ready  in  1  features valid
- lines_cleared  in  3  feature input
- holes  in  8  feature input
- bumpiness  in  8  feature input
- height_sum  in  8  feature input
- busy  out  1  high whenever state != IDLE
- search_done  out  1  one-cycle pulse on search completion
- best_valid  out  1  at least one legal candidate was found
- best_rot  out  2  rotation of the best candidate
- best_col  out  4  column of the best candidate
- best_score  out  20  signed score of the best candidate

Behaviour:
- Reset (async): all outputs 0; state IDLE; counters 0; internal best score = SCORE_MIN (-2^19).
- FSM states: IDLE, REQ, EXTRACT, SCORE, COMPARE, NEXT, DONE.
- IDLE:
  - start_search=1 → clear rot/col counters, set best to SCORE_MIN, clear best_valid, go to REQ.
  - start_search while busy is ignored.
- REQ:
  - cand_req=1 with cand_rot/cand_col held stable.
  - On cand_ack: drop cand_req next cycle.
  - cand_legal=1 → go to EXTRACT; cand_legal=0 → go to NEXT (no extraction).
- EXTRACT:
  - start_extract=1.
  - extract_ready is ignored on the first EXTRACT cycle, because it may be stale high from the previous candidate.
  - From the second cycle onward, extract_ready=1 → latch the four features, drop start_extract, go to SCORE.
- SCORE: one registered cycle computing score = W_LINES*lines - W_HOLES*holes - W_BUMP*bumpiness - W_HEIGHT*height_sum.
  - All operands are zero-extended into a 20-bit signed result.
  - Worst case is -3*255*255 = -195075, so no overflow and no saturation is needed.
- COMPARE:
  - score > best (strictly greater) → update best_score/rot/col and set best_valid=1.
  - Ties keep the earlier candidate.
- NEXT:
  - col == NUM_COL-1 → col = 0, rot++.
  - If that was the final candidate, go to DONE; otherwise go to REQ.
  - NEXT provides at least one cycle with start_extract low, so the extractor can return to IDLE.
- DONE: search_done=1 for exactly one cycle, then IDLE.
- best_* outputs hold their values until the next start_search is accepted.
- No legal candidates: best_valid=0, best_rot=0, best_col=0, best_score=SCORE_MIN.
- Latency:
  - Legal candidate: REQ(>=1) + EXTRACT(>=2) + SCORE + COMPARE + NEXT.
  - Illegal candidate: REQ + NEXT.
- No timeouts: waits on cand_ack or extract_ready are unbounded.
- Reset mid-search: immediate abort to the reset state; no search_done pulse.

Optional Feature:
- Macro: T01_AI_ABORT_EN.
- Defined:
  - Adds input port abort_search (1 bit).
  - When asserted in any busy state, cand_req and start_extract drop in the same cycle and the FSM goes to DONE.
  - search_done pulses and reports the best candidate so far, with best_valid reflecting it.
  - Abort in IDLE is ignored.
- Undefined: the port is absent and a search always runs to completion.

Decomposition:
- Package t01_ai_pkg holds:
  - scorer state enum typedef;
  - SCORE_W=20;
  - SCORE_MIN = -2^19;
  - default weight localparams.
- Sub-module t01_ai_score_calc: registered weighted-sum datapath; takes features and weights, produces a 20-bit signed score with one-cycle latency.
- The FSM, counters and best tracking stay in the top module.

Test Plan:
- All 40 candidates legal, features all 0 except candidate rot=2,col=7 with lines=4 → best_rot=2, best_col=7, best_score=304, best_valid=1, one search_done pulse.
- All candidates illegal (cand_legal=0) → start_extract never asserted; done after 40 REQ/NEXT passes; best_valid=0, best_score=-524288.
- Two candidates tie at score -100 (rot0 col3, rot1 col5), all others -500 → best is rot0 col3.
- extract_ready held high (stale) when EXTRACT is entered → not sampled on the first cycle; features latched only after ready re-rises; a single extraction per candidate.
- Max penalty: holes=bumpiness=height_sum=255, lines=0, all weights 255 → score -195075, no wrap.
- Reset asserted during EXTRACT → all outputs 0 immediately, start_extract low, no search_done pulse. With T01_AI_ABORT_EN defined, abort on candidate 12 → search_done pulse with best of the first 12 candidates.
